// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, drives the word-addressed byte-lane memory_map port.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses instead of force-aligning.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [3:0]        mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
    // a response transfers on a rising edge with rsp_valid && rsp_ready; neither
    // valid depends combinationally on the opposite ready.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;
    logic [3:0]        be_q;

    logic              accept;
    logic              illegal_f3;
    logic              misaligned;
    logic              req_err;
    logic [DATA_W-1:0] st_wdata;
    logic [3:0]        st_be;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;

    assign accept = (state == IDLE) && req_valid;

    // Unsigned sizes only exist for loads, so any 1xx store is illegal too.
    assign illegal_f3 = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111) || (req_funct3[2] && req_we);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_err = illegal_f3 || misaligned;

    always_comb begin
        st_wdata = req_wdata;
        st_be    = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_be    = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = req_wdata;
                st_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_read_data[7:0];
        case (lane_q)
            2'd0:    ld_byte = mem_read_data[7:0];
            2'd1:    ld_byte = mem_read_data[15:8];
            2'd2:    ld_byte = mem_read_data[23:16];
            default: ld_byte = mem_read_data[31:24];
        endcase
        ld_half = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_data = mem_read_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = req_err ? RESP : ACCESS;
            ACCESS:  state_nx = we_q ? RESP : WAIT;
            WAIT:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Memory-side address/data are loaded only for real accesses so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q           <= 1'b0;
            funct3_q       <= 3'b000;
            lane_q         <= 2'b00;
            be_q           <= 4'b0000;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else if (accept) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            lane_q    <= req_addr[1:0];
            rsp_err   <= req_err;
            rsp_rdata <= '0;
            if (!req_err) begin
                mem_address    <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_write_data <= st_wdata;
                be_q           <= st_be;
            end
        end else if (state == WAIT) begin
            rsp_rdata <= ld_data;
        end
    end

    // Decoded from the async-reset state so the enables drop the moment reset asserts.
    assign mem_write_enable = ((state == ACCESS) && we_q) ? be_q : 4'b0000;
    assign req_ready        = (state == IDLE);
    assign rsp_valid        = (state == RESP);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read memory model and response scoreboard.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_read_data;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    int we_cycles = 0;
    logic [31:0] last_wa, last_wd;
    logic [3:0]  last_we;
    logic        seen = 1'b0;

    logic [32:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] mem[logic [29:0]];

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return 32'h0;
    endfunction

    // memory_map model: one-cycle registered read, byte-lane writes
    always @(posedge clk) begin
        logic [31:0] w;
        w = mem_rd(mem_address);
        mem_read_data <= w;
        if (mem_write_enable != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (mem_write_enable[b]) w[8*b +: 8] = mem_write_data[8*b +: 8];
            mem[mem_address[31:2]] = w;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // write-port monitor
    always @(negedge clk) begin
        if (rst_n && mem_write_enable != 4'b0000) begin
            we_cycles++;
            last_wa = mem_address;
            last_wd = mem_write_data;
            last_we = mem_write_enable;
        end
    end

    // scoreboard: latency on first rsp_valid, data/err on the handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid && !seen) begin
            seen = 1'b1;
            if (lat_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
            else check("latency", 32'(cyc - acc_cyc), 32'(lat_q[0]));
        end
        if (rst_n && rsp_valid && rsp_ready) begin
            seen = 1'b0;
            if (exp_q.size() != 0) begin
                logic [32:0] e;
                e = exp_q.pop_front();
                void'(lat_q.pop_front());
                check("rsp_rdata", rsp_rdata, e[32:1]);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, e[0]});
            end
        end
    end

    // driver
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat, input bit wait_done);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        exp_q.push_back({exp_rdata, exp_err});
        lat_q.push_back(exp_lat);
        acc_cyc = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (wait_done) begin
            n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) check("rsp_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [31:0] word0;
        int n;
        mem[30'h10] = 32'h808182F3;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_write_data", mem_write_data, 32'h0);
        check("rst_mem_we", {28'b0, mem_write_enable}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, 3'b000, 32'h40, 32'h0, 32'hFFFFFFF3, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b100, 32'h43, 32'h0, 32'h00000080, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF8081, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b101, 32'h42, 32'h0, 32'h00008081, 1'b0, 3, 1'b1);

        w0 = we_cycles;
        issue(1'b1, 3'b000, 32'h41, 32'h000000AB, 32'h0, 1'b0, 2, 1'b1);
        check("sb_we_cycles", 32'(we_cycles - w0), 32'd1);
        check("sb_addr", last_wa, 32'h40);
        check("sb_wdata", last_wd, 32'hABABABAB);
        check("sb_be", {28'b0, last_we}, 32'b0010);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h8081ABF3, 1'b0, 3, 1'b1);

        w0 = we_cycles;
        issue(1'b1, 3'b010, 32'h1000_0000, 32'h3FF, 32'h0, 1'b0, 2, 1'b1);
        check("sw_we_cycles", 32'(we_cycles - w0), 32'd1);
        check("sw_be", {28'b0, last_we}, 32'hF);
        check("sw_addr", last_wa, 32'h1000_0000);
        issue(1'b0, 3'b010, 32'h1000_0000, 32'h0, 32'h000003FF, 1'b0, 3, 1'b1);

        w0 = we_cycles;
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue(1'b0, 3'b001, 32'h41, 32'h0, 32'h0, 1'b1, 1, 1'b1);
`else
        issue(1'b0, 3'b010, 32'h42, 32'h0, 32'h8081ABF3, 1'b0, 3, 1'b1);
        issue(1'b0, 3'b001, 32'h41, 32'h0, 32'hFFFFABF3, 1'b0, 3, 1'b1);
`endif
        // store with an unsigned size is illegal
        issue(1'b1, 3'b100, 32'h40, 32'h55, 32'h0, 1'b1, 1, 1'b1);
        check("err_no_write", 32'(we_cycles - w0), 32'd0);

        // illegal funct3 under backpressure
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        issue(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1, 1'b0);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'h0);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("illegal_no_write", 32'(we_cycles - w0), 32'd0);

        // reset during store ACCESS
        word0 = mem_rd(32'h40);
        w0 = we_cycles;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_store_we_high", {28'b0, mem_write_enable}, 32'hF);
        #1 rst_n = 1'b0;
        #1 check("rst_store_we_drop", {28'b0, mem_write_enable}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mem_unchanged", mem_rd(32'h40), word0);
        check("rst_no_write", 32'(we_cycles - w0), 32'd0);
        check("rst_rel_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        // unit still works after the aborted store
        issue(1'b0, 3'b010, 32'h40, 32'h0, word0, 1'b0, 3, 1'b1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the data-side memory_map.
- Accepts one load/store request at a time over a valid/ready handshake and drives the word-addressed, byte-lane memory_map port.
- Waits out the memory's one-cycle registered read, then extracts and sign/zero-extends byte/halfword load data.
- Returns a single response per request over a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  extended load data; 0 for stores
- rsp_err  out  1  illegal size, or misaligned when the optional feature is on
- mem_address  out  ADDR_W  to memory_map address
- mem_write_data  out  DATA_W  to memory_map write_data
- mem_write_enable  out  4  to memory_map byte-lane write enables
- mem_read_data  in  DATA_W  from memory_map read_data

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_address=0; mem_write_data=0; mem_write_enable=0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register addr, we, funct3 and wdata.
  - If funct3 is illegal (011/110/111, or 1xx with we=1): go to RESP with rsp_err=1; no memory access.
  - Otherwise go to ACCESS.
- ACCESS (1 cycle):
  - mem_address = {addr[ADDR_W-1:2], 2'b00}.
  - Store: mem_write_enable is asserted this cycle only; next state RESP.
  - Load: mem_write_enable=0; next state WAIT.
- WAIT (1 cycle, load only):
  - mem_address is held.
  - mem_read_data is valid this cycle; capture the extracted value into rsp_rdata at the cycle end.
  - Next state RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - A new request is not accepted in the same cycle.
- mem_address holds its last value in IDLE/RESP. mem_write_enable is 0 in every state except store-ACCESS.
- Store lane formatting:
  - B: write_data = {4{wdata[7:0]}}, enable = 4'b0001 << addr[1:0].
  - H: write_data = {2{wdata[15:0]}}, enable = addr[1] ? 4'b1100 : 4'b0011.
  - W: write_data = wdata, enable = 4'b1111.
- Load extraction:
  - B/BU: select byte addr[1:0]; B sign-extends from bit 7, BU zero-extends.
  - H/HU: select half addr[1]; H sign-extends from bit 15, HU zero-extends.
  - W: pass through.
- Latency, acceptance edge to rsp_valid high:
  - load: 3 cycles
  - store: 2 cycles
  - error: 1 cycle
- Throughput: one request per (latency + 1) cycles, with rsp_ready held high.
- Reset mid-operation: immediate return to IDLE. mem_write_enable drops to 0 asynchronously, and an in-flight response is discarded.
- Backpressure: rsp_ready low holds RESP indefinitely; no memory traffic occurs while held.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - H with addr[0]=1, or W with addr[1:0]!=0, goes IDLE→RESP with rsp_err=1.
  - No memory access occurs; rsp_rdata=0.
- Undefined:
  - Misaligned accesses are force-aligned: H uses addr[1] only; W ignores addr[1:0].
  - rsp_err is raised only for illegal funct3.

Test Plan:
- Memory word 0x40 = 0x808182F3; LB @0x40 → rsp_rdata=0xFFFFFFF3, rsp_valid exactly 3 cycles after acceptance; LBU @0x43 → 0x00000080; LH @0x42 → 0xFFFF8081; LHU @0x42 → 0x00008081.
- SB @0x41, wdata=0x000000AB → one cycle of mem_address=0x40, mem_write_data=0xABABABAB, mem_write_enable=4'b0010; a following LW @0x40 returns 0x8081ABF3.
- SW @0x1000_0000, wdata=0x3FF → mem_write_enable=4'b1111 for one cycle; LW @0x1000_0000 returns 0x000003FF.
- LW @0x42:
  - With LSU_MISALIGN_TRAP_EN: rsp_err=1 after 1 cycle and no write_enable activity.
  - Without it: reads word 0x40, rsp_err=0.
- Illegal funct3=3'b011 → rsp_err=1, rsp_rdata=0, mem_write_enable never asserted. rsp_ready held low 4 cycles → rsp_valid/rsp_rdata stable and req_ready=0 throughout.
- Assert rst_n=0 during store ACCESS → mem_write_enable=0 in the same cycle; memory word unchanged; after release req_ready=1 and rsp_valid=0.
